// File: rtl/bsg_cache_dma_mem_responder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | bsg_cache_dma_mem_responder: word-array memory serving bsg_cache DMA       |
// | fill (read) and evict (write) bursts.                     Revision: 1.0    |
// +---------------------------------------------------------------------------+
module bsg_cache_dma_mem_responder #(
  parameter int addr_width_p          = 32,
  parameter int data_width_p          = 32,
  parameter int block_size_in_words_p = 8,
  parameter int mem_els_p             = 1024,
  parameter int read_delay_p          = 0
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [addr_width_p:0]   dma_pkt_i,
  input  logic                    dma_pkt_v_i,
  output logic                    dma_pkt_yumi_o,
  output logic [data_width_p-1:0] dma_data_o,
  output logic                    dma_data_v_o,
  input  logic                    dma_data_ready_i,
  input  logic [data_width_p-1:0] dma_data_i,
  input  logic                    dma_data_v_i,
  output logic                    dma_data_yumi_o
);

  localparam int lg_bytes  = $clog2(data_width_p / 8);
  localparam int lg_mem    = $clog2(mem_els_p);
  localparam int lg_block  = $clog2(block_size_in_words_p);
  localparam int idx_width = (addr_width_p > lg_mem) ? addr_width_p : lg_mem;
  localparam int dly_width = (read_delay_p > 1) ? $clog2(read_delay_p) : 1;
  // RDELAY is left when the counter reaches zero, so load one less than the delay
  localparam logic [dly_width-1:0] dly_load =
    dly_width'((read_delay_p > 0) ? read_delay_p - 1 : 0);
  localparam logic [lg_mem-1:0] block_mask = lg_mem'(block_size_in_words_p - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RDELAY = 2'd1,
    READ   = 2'd2,
    WRITE  = 2'd3
  } state_e;

  state_e                  state;
  logic [lg_block-1:0]     beat;
  logic [dly_width-1:0]    dly;
  logic [lg_mem-1:0]       base;
  logic [data_width_p-1:0] mem [mem_els_p];

  logic                    pkt_write;
  logic [lg_mem-1:0]       pkt_base;
  logic [lg_mem-1:0]       mem_addr;
  logic                    last_beat;

  // Address bits above the array are dropped, so large addresses alias
  assign pkt_write = dma_pkt_i[addr_width_p];
  assign pkt_base  = lg_mem'(idx_width'(dma_pkt_i[addr_width_p-1:0]) >> lg_bytes) & ~block_mask;
  assign mem_addr  = base | lg_mem'(beat);
  assign last_beat = &beat;

  assign dma_pkt_yumi_o  = (state == IDLE) && dma_pkt_v_i;
  assign dma_data_v_o    = (state == READ);
  assign dma_data_o      = (state == READ) ? mem[mem_addr] : '0;
  assign dma_data_yumi_o = (state == WRITE) && dma_data_v_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
      beat  <= '0;
      dly   <= '0;
      base  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dma_pkt_v_i) begin
            base <= pkt_base;
            beat <= '0;
            if (pkt_write) begin
              state <= WRITE;
            end else if (read_delay_p == 0) begin
              state <= READ;
            end else begin
              state <= RDELAY;
              dly   <= dly_load;
            end
          end
        end
        RDELAY: begin
          if (dly == '0) state <= READ;
          else           dly   <= dly - dly_width'(1);
        end
        READ: begin
          if (dma_data_ready_i) begin
            beat <= beat + lg_block'(1);
            if (last_beat) state <= IDLE;
          end
        end
        WRITE: begin
          if (dma_data_v_i) begin
            beat <= beat + lg_block'(1);
            if (last_beat) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < mem_els_p; i++) mem[i] <= '0;
    end else if (dma_data_yumi_o) begin
      mem[mem_addr] <= dma_data_i;
    end
  end

endmodule
`default_nettype wire
